fetch_sequencer: RTL and testbench

// - Instruction-fetch controller for the 5-stage core. It drives the program counter's increment,

---
 rtl/fetch_sequencer.sv | 126 ++++++++++++
 tb/tb_fetch_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: boots, paces and redirects instruction fetch, flushing younger stages after each redirect
// Optional interrupt entry/return path enabled by defining FETCH_IRQ_EN.
module fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [15:0] IRQ_VECTOR   = 16'hFFF0
) (
  input  logic        clock,
  input  logic        reset,
`ifdef FETCH_IRQ_EN
  input  logic        irq,
  input  logic        irq_ret,
  output logic        irq_ack,
  output logic [15:0] epc,
`endif
  input  logic [15:0] pc_count,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        imem_ack,
  output logic        pc_increment,
  output logic        pc_jump_set,
  output logic [15:0] pc_jumpcount,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic        fetch_valid,
  output logic        flush
);
  typedef enum logic [1:0] {BOOT, FETCH, WAIT, FLUSH} state_t;
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic redirect;
  logic [15:0] target;
  assign imem_addr = pc_count;
`ifdef FETCH_IRQ_EN
  logic irq_mask, ret_take;
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_mask <= 1'b0;
      epc <= 16'h0000;
    end else if (irq_ack) begin
      irq_mask <= 1'b1;
      epc <= pc_count;
    end else if (ret_take) irq_mask <= 1'b0;
  end
`else
  logic unused_irq_vector;
  assign unused_irq_vector = ^IRQ_VECTOR;
`endif
  always_ff @(posedge clock) begin
    state <= state_n;
    cnt <= cnt_n;
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pc_increment = 1'b0;
    pc_jump_set = 1'b0;
    pc_jumpcount = RESET_VECTOR;
    imem_req = 1'b0;
    fetch_valid = 1'b0;
    flush = 1'b0;
    redirect = 1'b0;
    target = branch_target;
`ifdef FETCH_IRQ_EN
    irq_ack = 1'b0;
    ret_take = 1'b0;
`endif
    if (reset) begin
      state_n = BOOT;
      cnt_n = 3'd0;
    end else begin
      case (state)
        BOOT: begin
          pc_jump_set = 1'b1;
          state_n = FETCH;
        end
        FETCH: begin
          if (branch_taken) redirect = 1'b1;
`ifdef FETCH_IRQ_EN
          else if (irq && !stall && !irq_mask) begin
            redirect = 1'b1;
            target = IRQ_VECTOR;
            irq_ack = 1'b1;
          end else if (irq_ret) begin
            redirect = 1'b1;
            target = epc;
            ret_take = 1'b1;
          end
`endif
          else if (!stall) begin
            imem_req = 1'b1;
            fetch_valid = imem_ack;
            pc_increment = imem_ack;
            state_n = imem_ack ? FETCH : WAIT;
          end
        end
        WAIT: begin
          if (branch_taken) redirect = 1'b1;
          else begin
            imem_req = 1'b1;
            fetch_valid = imem_ack && !stall;
            pc_increment = imem_ack && !stall;
            state_n = imem_ack ? FETCH : WAIT;
          end
        end
        default: begin
          flush = 1'b1;
          if (branch_taken) redirect = 1'b1;
          else begin
            cnt_n = cnt - 3'd1;
            state_n = (cnt <= 3'd1) ? FETCH : FLUSH;
          end
        end
      endcase
      // a redirect cancels any outstanding request and restarts the flush window
      if (redirect) begin
        pc_jump_set = 1'b1;
        pc_jumpcount = target;
        flush = 1'b1;
        cnt_n = 3'(FLUSH_CYCLES - 1);
        state_n = (FLUSH_CYCLES == 1) ? FETCH : FLUSH;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scoreboard bench with a behavioural program counter around the sequencer
module tb_fetch_sequencer;
  logic clock = 1'b0, reset = 1'b1, stall = 1'b0, branch_taken = 1'b0, imem_ack = 1'b0;
  logic [15:0] branch_target = 16'h0000, pc = 16'hBEEF;
  logic pc_increment, pc_jump_set, imem_req, fetch_valid, flush;
  logic [15:0] pc_jumpcount, imem_addr;
`ifdef FETCH_IRQ_EN
  logic irq = 1'b0, irq_ret = 1'b0, irq_ack;
  logic [15:0] epc;
`endif
  typedef struct packed {
    logic inc, js;
    logic [15:0] jc;
    logic req;
    logic [15:0] addr;
    logic fv, fl, ia;
    logic [15:0] epc;
  } rec_t;
  typedef struct {rec_t r; logic jcc, ec; int id;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, n_step = 0;
  logic xi = 1'b0, xr = 1'b0, xia = 1'b0, xec = 1'b0;
  logic [15:0] xepc = 16'h0000;
  fetch_sequencer dut (
    .clock(clock), .reset(reset),
`ifdef FETCH_IRQ_EN
    .irq(irq), .irq_ret(irq_ret), .irq_ack(irq_ack), .epc(epc),
`endif
    .pc_count(pc), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_ack(imem_ack), .pc_increment(pc_increment), .pc_jump_set(pc_jump_set),
    .pc_jumpcount(pc_jumpcount), .imem_req(imem_req), .imem_addr(imem_addr),
    .fetch_valid(fetch_valid), .flush(flush)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    if (pc_jump_set) pc <= pc_jumpcount;
    else if (pc_increment) pc <= pc + 16'd1;
  end
  task automatic step(input logic r, s, b, input logic [15:0] t, input logic a,
                      input logic inc, js, input logic [15:0] jc, input logic req,
                      input logic [15:0] addr, input logic fv, fl);
    exp_t e;
    @(posedge clock);
    #1;
    reset = r; stall = s; branch_taken = b; branch_target = t; imem_ack = a;
`ifdef FETCH_IRQ_EN
    irq = xi; irq_ret = xr;
`endif
    n_step++;
    e.r = '{inc: inc, js: js, jc: jc, req: req, addr: addr, fv: fv, fl: fl, ia: xia, epc: xepc};
    e.jcc = js | r;
    e.ec = xec;
    e.id = n_step;
    q.push_back(e);
  endtask
  task automatic istep(input logic i, ir, ia, ec, input logic [15:0] ep);
    xi = i; xr = ir; xia = ia; xec = ec; xepc = ep;
  endtask
  always @(negedge clock) begin
    if (reset) begin
      n_cmp++;
      if ({pc_increment, pc_jump_set, imem_req, fetch_valid, flush} !== 5'b0 || pc_jumpcount !== 16'h0000) begin
        n_bad++;
        $display("FAIL reset state: inc=%b js=%b req=%b fv=%b fl=%b jc=%h",
                 pc_increment, pc_jump_set, imem_req, fetch_valid, flush, pc_jumpcount);
      end
    end
    n_cmp++;
    if ((pc_increment & pc_jump_set) !== 1'b0) begin
      n_bad++;
      $display("FAIL exclusivity: pc_increment and pc_jump_set both high");
    end
    if (q.size() > 0) begin
      exp_t e;
      rec_t act;
      e = q.pop_front();
      act = '{inc: pc_increment, js: pc_jump_set, jc: e.jcc ? pc_jumpcount : e.r.jc, req: imem_req,
              addr: imem_addr, fv: fetch_valid, fl: flush, ia: e.r.ia, epc: e.r.epc};
`ifdef FETCH_IRQ_EN
      act.ia = irq_ack;
      act.epc = e.ec ? epc : e.r.epc;
`endif
      n_cmp++;
      if (act !== e.r) begin
        n_bad++;
        $display("FAIL step%0d: got %h want %h", e.id, act, e.r);
      end
    end
  end
  initial begin
    step(1,0,0,16'h0000,0, 0,0,16'h0000,0,16'hBEEF,0,0);
`ifdef FETCH_IRQ_EN
    istep(0,0,0,1,16'h0000);
`endif
    step(1,0,0,16'h0000,0, 0,0,16'h0000,0,16'hBEEF,0,0);
    istep(0,0,0,0,16'h0000);
    step(1,0,0,16'h0000,0, 0,0,16'h0000,0,16'hBEEF,0,0);
    step(0,0,0,16'h0000,0, 0,1,16'h0000,0,16'hBEEF,0,0);
    step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'h0000,1,0);
    step(0,0,1,16'h0010,1, 0,1,16'h0010,0,16'h0001,0,1);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,0,16'h0010,0,1);
    for (int i = 0; i < 4; i++)
      step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'h0010 + 16'(i),1,0);
    step(0,0,1,16'h0020,0, 0,1,16'h0020,0,16'h0014,0,1);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,0,16'h0020,0,1);
    for (int i = 0; i < 3; i++)
      step(0,0,0,16'h0000,0, 0,0,16'h0000,1,16'h0020,0,0);
    step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'h0020,1,0);
    step(0,1,0,16'h0000,1, 0,0,16'h0000,0,16'h0021,0,0);
    step(0,1,0,16'h0000,0, 0,0,16'h0000,0,16'h0021,0,0);
    step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'h0021,1,0);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,1,16'h0022,0,0);
    step(0,1,0,16'h0000,1, 0,0,16'h0000,1,16'h0022,0,0);
    step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'h0022,1,0);
    step(0,1,1,16'h0100,1, 0,1,16'h0100,0,16'h0023,0,1);
    step(0,0,0,16'h0000,1, 0,0,16'h0000,0,16'h0100,0,1);
    step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'h0100,1,0);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,1,16'h0101,0,0);
    step(0,0,1,16'h0200,1, 0,1,16'h0200,0,16'h0101,0,1);
    step(0,0,1,16'h0300,0, 0,1,16'h0300,0,16'h0200,0,1);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,0,16'h0300,0,1);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,1,16'h0300,0,0);
    step(1,0,0,16'h0000,1, 0,0,16'h0000,0,16'h0300,0,0);
    step(0,0,1,16'h0500,0, 0,1,16'h0000,0,16'h0300,0,0);
    step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'h0000,1,0);
    step(0,0,1,16'hFFFF,0, 0,1,16'hFFFF,0,16'h0001,0,1);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,0,16'hFFFF,0,1);
    step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'hFFFF,1,0);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,1,16'h0000,0,0);
`ifdef FETCH_IRQ_EN
    step(0,0,1,16'h0042,0, 0,1,16'h0042,0,16'h0000,0,1);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,0,16'h0042,0,1);
    istep(1,0,1,0,16'h0000);
    step(0,0,0,16'h0000,1, 0,1,16'hFFF0,0,16'h0042,0,1);
    istep(1,0,0,1,16'h0042);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,0,16'hFFF0,0,1);
    step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'hFFF0,1,0);
    istep(0,1,0,1,16'h0042);
    step(0,0,0,16'h0000,0, 0,1,16'h0042,0,16'hFFF1,0,1);
    istep(0,0,0,1,16'h0042);
    step(0,0,0,16'h0000,0, 0,0,16'h0000,0,16'h0042,0,1);
    step(0,0,0,16'h0000,1, 1,0,16'h0000,1,16'h0042,1,0);
`endif
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
